// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmitter and its matching receiver.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int DEFAULT_CLKS_PER_BIT = 4;
  localparam int DEFAULT_DATA_BITS    = 8;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int width_for(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_transmitter_bit_timer.sv
// Per-bit cycle counter: runs 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module bit_timer
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_end
);

  localparam int CW = width_for(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count_q, count_d;

  assign bit_end = (count_q == LAST);

  // Wrapping on bit_end keeps CLKS_PER_BIT=1 pinned at zero.
  always_comb begin
    count_d = count_q + CW'(1);
    if (clear || bit_end) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/serial_transmitter.sv
// Framed serial transmitter: start bit, LSB-first payload, stop bit, registered outputs.
module serial_transmitter
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEFAULT_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] data,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int IW = width_for(DATA_BITS);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IW-1:0]        bit_idx_q, bit_idx_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 timer_clear;
  logic                 bit_end;

  assign timer_clear = (state_q == IDLE);

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .bit_end(bit_end)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (start) begin
          shift_d = data;
          state_d = START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          bit_idx_d = '0;
          tx_d      = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx_q == LAST_BIT) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + IW'(1);
            tx_d      = shift_q[1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          done_d = 1'b1;
          // A waiting request chains straight into the next start bit.
          if (start) begin
            shift_d = data;
            state_d = START;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_serial_transmitter.sv
// Directed and randomized frame checks against a slot-based waveform model.
module tb_serial_transmitter;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_v [3];
  logic [7:0] data_v  [3];
  logic       tx_v    [3];
  logic       busy_v  [3];
  logic       done_v  [3];
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  serial_transmitter #(.CLKS_PER_BIT(4), .DATA_BITS(8)) dut_main (
    .clk(clk), .reset(reset), .start(start_v[0]), .data(data_v[0]),
    .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]));

  serial_transmitter #(.CLKS_PER_BIT(1), .DATA_BITS(8)) dut_fast (
    .clk(clk), .reset(reset), .start(start_v[1]), .data(data_v[1]),
    .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]));

  serial_transmitter #(.CLKS_PER_BIT(4), .DATA_BITS(5)) dut_narrow (
    .clk(clk), .reset(reset), .start(start_v[2]), .data(data_v[2][4:0]),
    .tx(tx_v[2]), .busy(busy_v[2]), .done(done_v[2]));

  function automatic int cpb(input int i);
    return (i == 1) ? 1 : 4;
  endfunction

  function automatic int nbits(input int i);
    return (i == 2) ? 5 : 8;
  endfunction

  // Line level k cycles after the accepting edge: slot 0 start, then payload LSB first, then stop.
  function automatic logic exp_tx(input int i, input logic [7:0] d, input int k);
    int slot;
    slot = k / cpb(i);
    if (slot == 0) return 1'b0;
    if (slot > nbits(i)) return 1'b1;
    return d[slot-1];
  endfunction

  function automatic logic [7:0] rnd_data(input int i);
    logic [7:0] r;
    r = 8'($urandom);
    return (i == 2) ? (r & 8'h1F) : r;
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input int i, input string tag);
    chk({tag, " tx"}, tx_v[i], 1'b1);
    chk({tag, " busy"}, busy_v[i], 1'b0);
    chk({tag, " done"}, done_v[i], 1'b0);
  endtask

  // Called at the sample point just after the accepting edge; leaves us just after the final edge.
  task automatic check_frame(input int i, input logic [7:0] d, input bit chained, input int poke_k);
    int len;
    len = (nbits(i) + 2) * cpb(i);
    for (int k = 0; k < len; k++) begin
      if (poke_k >= 0 && k == poke_k) begin
        start_v[i] = 1'b1;
        data_v[i]  = 8'hFF;
      end else if (poke_k >= 0 && k == poke_k + 1) begin
        start_v[i] = 1'b0;
      end
      chk($sformatf("u%0d d=%02h k=%0d tx", i, d, k), tx_v[i], exp_tx(i, d, k));
      chk($sformatf("u%0d d=%02h k=%0d busy", i, d, k), busy_v[i], 1'b1);
      chk($sformatf("u%0d d=%02h k=%0d done", i, d, k), done_v[i], (k == 0) && chained);
      tick();
    end
    $display("[TB] unit %0d frame data=%02h chained=%0d checked over %0d cycles", i, d, chained, len);
  endtask

  task automatic check_end(input int i);
    chk($sformatf("u%0d end tx", i), tx_v[i], 1'b1);
    chk($sformatf("u%0d end busy", i), busy_v[i], 1'b0);
    chk($sformatf("u%0d end done", i), done_v[i], 1'b1);
    tick();
    chk_idle(i, $sformatf("u%0d after done", i));
  endtask

  task automatic launch(input int i, input logic [7:0] d);
    start_v[i] = 1'b1;
    data_v[i]  = d;
    tick();
    start_v[i] = 1'b0;
  endtask

  task automatic random_burst(input int i);
    int         n;
    logic [7:0] d, nd;
    n = $urandom_range(1, 3);
    for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
      tick();
      chk_idle(i, $sformatf("u%0d gap", i));
    end
    d = rnd_data(i);
    start_v[i] = 1'b1;
    data_v[i]  = d;
    tick();
    for (int f = 0; f < n; f++) begin
      nd = rnd_data(i);
      if (f == n - 1) start_v[i] = 1'b0;
      else data_v[i] = nd;
      check_frame(i, d, f > 0, -1);
      d = nd;
    end
    check_end(i);
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b1;
      data_v[i]  = 8'hA5;
    end
    tick();
    tick();
    for (int i = 0; i < 3; i++) chk_idle(i, $sformatf("u%0d in reset with start", i));
    for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
    #2 reset = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) chk_idle(i, $sformatf("u%0d after reset", i));

    launch(0, 8'hA5);
    check_frame(0, 8'hA5, 1'b0, -1);
    check_end(0);

    start_v[0] = 1'b1;
    data_v[0]  = 8'h3C;
    tick();
    data_v[0]  = 8'hC3;
    check_frame(0, 8'h3C, 1'b0, -1);
    start_v[0] = 1'b0;
    check_frame(0, 8'hC3, 1'b1, -1);
    check_end(0);

    launch(0, 8'h00);
    check_frame(0, 8'h00, 1'b0, 10);
    check_end(0);
    for (int j = 0; j < 6; j++) begin
      tick();
      chk_idle(0, "no second frame");
    end

    launch(0, 8'h5A);
    for (int k = 0; k < 17; k++) begin
      chk($sformatf("pre-abort k=%0d tx", k), tx_v[0], exp_tx(0, 8'h5A, k));
      tick();
    end
    #2 reset = 1'b1;
    #1 chk_idle(0, "async reset mid-frame");
    tick();
    chk_idle(0, "held reset");
    #3 reset = 1'b0;
    for (int j = 0; j < 45; j++) begin
      tick();
      chk_idle(0, "after abort");
    end
    launch(0, 8'h5A);
    check_frame(0, 8'h5A, 1'b0, -1);
    check_end(0);

    launch(1, 8'hFF);
    check_frame(1, 8'hFF, 1'b0, -1);
    check_end(1);

    launch(2, 8'h11);
    check_frame(2, 8'h11, 1'b0, -1);
    check_end(2);

    for (int r = 0; r < 12; r++) random_burst(r % 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
